// File: rtl/mest_run_pkg.sv
// Shared types for the mest_pro run controller: FSM state encoding,
// capture entry layout and the capture word width helper.
package mest_run_pkg;

   // Sequencer states; the encoding is also visible on the debug port.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_MEMRST = 3'd1,
      S_START  = 3'd2,
      S_RUN    = 3'd3,
      S_NEXT   = 3'd4,
      S_DONE   = 3'd5
   } run_state_t;

   // Result width of the stock mest_pro core.
   localparam int RESULT_W = 8;

   // One captured result, most significant field first: {carry, zero, result}.
   typedef struct packed {
      logic                carry;
      logic                zero;
      logic [RESULT_W-1:0] result;
   } capture_entry_t;

   // A capture word carries the result plus the two core flags.
   function automatic int CAPTURE_W(input int data_width);
      return data_width + 2;
   endfunction

endpackage

// File: rtl/mest_run_capture_ram.sv
// Capture buffer: one write port, one registered read port, write-first
// when both ports address the same entry in the same cycle.
module mest_run_capture_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Storage array; contents are not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read, forwarding the incoming word on an address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (we && (wr_addr == rd_addr)) begin
         rd_data_q <= wr_data;
      end else begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/mest_run_ctrl.sv
// Run controller for a mest_pro core: holds the core in reset/memory reset,
// pulses start, captures valid results during each run and enforces a
// per-run timeout, for NUM_RUNS runs per i_go request.
// Optional feature: define MEST_RUN_CTRL_CHECKSUM_EN to add o_checksum, the
// rotate-left-by-1 XOR of every accepted capture entry.
//
// Handshake: i_go is a single-cycle request honoured only in IDLE or DONE;
// i_valid_result qualifies i_result/i_carry/i_zero_flag for one cycle with
// no backpressure, and is only acted on in RUN.
module mest_run_ctrl
   import mest_run_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int CAPTURE_DEPTH  = 16,
   parameter int NUM_RUNS       = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int MEMRST_CYCLES  = 4
) (
   input  logic                             clk,
   input  logic                             i_reset,
   input  logic                             i_go,
   input  logic [DATA_WIDTH-1:0]            i_result,
   input  logic                             i_valid_result,
   input  logic                             i_carry,
   input  logic                             i_zero_flag,
   input  logic                             i_all_done,
   output logic                             o_core_reset_n,
   output logic                             o_memory_reset,
   output logic                             o_start,
   input  logic [$clog2(CAPTURE_DEPTH)-1:0] i_rd_addr,
   output logic [DATA_WIDTH+1:0]            o_rd_data,
   output logic [$clog2(CAPTURE_DEPTH):0]   o_capture_count,
   output logic [$clog2(NUM_RUNS):0]        o_run_count,
   output logic                             o_busy,
   output logic                             o_done,
   output logic                             o_timeout,
   output logic                             o_overflow,
   output run_state_t                       o_dbg_state
`ifdef MEST_RUN_CTRL_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH+1:0]            o_checksum
`endif
);

   localparam int AW   = $clog2(CAPTURE_DEPTH);
   localparam int CW   = AW + 1;
   localparam int RW   = $clog2(NUM_RUNS) + 1;
   localparam int EW   = CAPTURE_W(DATA_WIDTH);
   localparam int TMAX = (TIMEOUT_CYCLES > MEMRST_CYCLES) ? TIMEOUT_CYCLES : MEMRST_CYCLES;
   localparam int TW   = $clog2(TMAX) + 1;

   run_state_t      state_q, state_d;
   logic [TW-1:0]   cnt_q, cnt_d;       // memory-reset length, then run timeout
   logic [CW-1:0]   cap_cnt_q, cap_cnt_d;
   logic [RW-1:0]   run_cnt_q, run_cnt_d;
   logic [RW-1:0]   run_inc;
   logic            tmo_q, tmo_d;
   logic            ovf_q, ovf_d;
   logic            core_reset_n_q, core_reset_n_d;
   logic            memory_reset_q, memory_reset_d;
   logic            start_q, start_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ram_we;
   logic [EW-1:0]   wr_entry;
   logic [AW-1:0]   wr_addr;
`ifdef MEST_RUN_CTRL_CHECKSUM_EN
   logic [EW-1:0]   chk_q, chk_d;
`endif

   assign wr_entry = {i_carry, i_zero_flag, i_result};
   assign wr_addr  = cap_cnt_q[AW-1:0];
   assign run_inc  = run_cnt_q + RW'(1);

   // Next-state, counter and flag logic; core controls follow the next state
   // so that every output is a flop aligned with the state it belongs to.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cap_cnt_d = cap_cnt_q;
      run_cnt_d = run_cnt_q;
      tmo_d     = tmo_q;
      ovf_d     = ovf_q;
      ram_we    = 1'b0;
`ifdef MEST_RUN_CTRL_CHECKSUM_EN
      chk_d     = chk_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (i_go) begin
               cap_cnt_d = '0;
               run_cnt_d = '0;
               tmo_d     = 1'b0;
               ovf_d     = 1'b0;
               cnt_d     = '0;
`ifdef MEST_RUN_CTRL_CHECKSUM_EN
               chk_d     = '0;
`endif
               state_d   = S_MEMRST;
            end
         end
         S_MEMRST: begin
            if (cnt_q == TW'(MEMRST_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = S_START;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         S_START: begin
            // The timeout window opens with the start pulse.
            cnt_d   = cnt_q + TW'(1);
            state_d = S_RUN;
         end
         S_RUN: begin
            if (i_valid_result) begin
               if (cap_cnt_q == CW'(CAPTURE_DEPTH)) begin
                  ovf_d = 1'b1;
               end else begin
                  ram_we    = 1'b1;
                  cap_cnt_d = cap_cnt_q + CW'(1);
`ifdef MEST_RUN_CTRL_CHECKSUM_EN
                  chk_d     = {chk_q[EW-2:0], chk_q[EW-1]} ^ wr_entry;
`else
                  // No running checksum in this build.
`endif
               end
            end
            if (i_all_done) begin
               state_d = S_NEXT;
            end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               tmo_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         S_NEXT: begin
            run_cnt_d = run_inc;
            cnt_d     = '0;
            state_d   = (run_inc < RW'(NUM_RUNS)) ? S_MEMRST : S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      core_reset_n_d = (state_d != S_MEMRST);
      memory_reset_d = (state_d == S_MEMRST);
      start_d        = (state_d == S_START);
      busy_d         = (state_d == S_MEMRST) || (state_d == S_START) ||
                       (state_d == S_RUN)    || (state_d == S_NEXT);
      done_d         = (state_d == S_DONE);
   end

   // State, counters, sticky flags and registered outputs.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         cap_cnt_q      <= '0;
         run_cnt_q      <= '0;
         tmo_q          <= 1'b0;
         ovf_q          <= 1'b0;
         core_reset_n_q <= 1'b0;
         memory_reset_q <= 1'b0;
         start_q        <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
`ifdef MEST_RUN_CTRL_CHECKSUM_EN
         chk_q          <= '0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         cap_cnt_q      <= cap_cnt_d;
         run_cnt_q      <= run_cnt_d;
         tmo_q          <= tmo_d;
         ovf_q          <= ovf_d;
         core_reset_n_q <= core_reset_n_d;
         memory_reset_q <= memory_reset_d;
         start_q        <= start_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
`ifdef MEST_RUN_CTRL_CHECKSUM_EN
         chk_q          <= chk_d;
`endif
      end
   end

   mest_run_capture_ram #(
      .DEPTH (CAPTURE_DEPTH),
      .WIDTH (EW)
   ) u_ram (
      .clk     (clk),
      .rst     (i_reset),
      .we      (ram_we),
      .wr_addr (wr_addr),
      .wr_data (wr_entry),
      .rd_addr (i_rd_addr),
      .rd_data (o_rd_data)
   );

   assign o_core_reset_n  = core_reset_n_q;
   assign o_memory_reset  = memory_reset_q;
   assign o_start         = start_q;
   assign o_capture_count = cap_cnt_q;
   assign o_run_count     = run_cnt_q;
   assign o_busy          = busy_q;
   assign o_done          = done_q;
   assign o_timeout       = tmo_q;
   assign o_overflow      = ovf_q;
   assign o_dbg_state     = state_q;
`ifdef MEST_RUN_CTRL_CHECKSUM_EN
   assign o_checksum      = chk_q;
`endif

endmodule

// File: doc/mest_run_ctrl.md
# mest_run_ctrl

Synthesizable run controller that sequences a `mest_pro` core through a parametrised number of program runs, capturing every valid result into an on-chip buffer. It drives the core's reset, memory-reset and start inputs, watches `o_all_done`, and enforces a per-run timeout. It replaces the hand-written stimulus wrapper at the top of the processor hierarchy, so the same sequencing works in simulation and on the board.

## Interface
- `DATA_WIDTH`, 8: width of the core result.
- `CAPTURE_DEPTH`, 16: capture buffer entries, a power of two ≥ 2.
- `NUM_RUNS`, 4: program runs per `i_go`, ≥ 1.
- `TIMEOUT_CYCLES`, 1024: maximum cycles in RUN before abort, ≥ 2.
- `MEMRST_CYCLES`, 4: cycles the core is held in reset/memory reset, ≥ 1.
- `clk` in 1: clock.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_go` in 1: single-cycle start-sequence request.
- `i_result` in DATA_WIDTH: core result.
- `i_valid_result` in 1: core result valid.
- `i_carry`, `i_zero_flag` in 1: core flags, sampled with `i_valid_result`.
- `i_all_done` in 1: core program complete.
- `o_core_reset_n` out 1: active-low reset to the core.
- `o_memory_reset` out 1: memory reset to the core.
- `o_start` out 1: start pulse to the core.
- `i_rd_addr` in $clog2(CAPTURE_DEPTH): capture read address.
- `o_rd_data` out DATA_WIDTH+2: {carry, zero, result} at `i_rd_addr`.
- `o_capture_count` out $clog2(CAPTURE_DEPTH)+1: entries written.
- `o_run_count` out $clog2(NUM_RUNS)+1: runs completed.
- `o_busy`, `o_done`, `o_timeout`, `o_overflow` out 1: status.

## Operation
- States: IDLE, MEMRST, START, RUN, NEXT, DONE.
- IDLE/DONE: `i_go` clears the capture count, run count, `o_timeout` and `o_overflow`, then moves to MEMRST. `i_go` is ignored in every other state.
- MEMRST: `o_core_reset_n`=0 and `o_memory_reset`=1 for exactly MEMRST_CYCLES cycles, then START.
- START: `o_start`=1 for one cycle. The timeout counter clears. Next state is RUN.
- RUN: each cycle with `i_valid_result`=1 writes {i_carry, i_zero_flag, i_result} at index `o_capture_count`, then increments the count.
  - When the count equals CAPTURE_DEPTH, the write is dropped and `o_overflow` is set (sticky).
  - `i_all_done` moves to NEXT.
  - If `i_all_done` has not arrived when the counter reaches TIMEOUT_CYCLES-1, `o_timeout` is set (sticky) and the state goes straight to DONE. The remaining runs are skipped.
- NEXT: `o_run_count` increments. If the new count is less than NUM_RUNS, go to MEMRST; otherwise go to DONE. The buffer accumulates across runs and is never cleared between them.
- DONE: `o_done`=1 until `i_go`.
- `o_busy`=1 in MEMRST, START, RUN and NEXT.
- Simultaneous `i_valid_result` and `i_all_done` in RUN: the result is captured, then the state moves to NEXT.
- Valid result in the timeout cycle: captured.
- Valid results outside RUN: ignored.
- Reset mid-sequence: all state is lost and the block returns to IDLE. Buffer contents are undefined, but the count is 0.

## Timing
- Reset values:
  - `o_core_reset_n`=0 (core held in reset).
  - `o_memory_reset`=0.
  - `o_start`=0, `o_busy`=0, `o_done`=0, `o_timeout`=0, `o_overflow`=0.
  - `o_capture_count`=0, `o_run_count`=0.
  - `o_rd_data`=0.
- `o_core_reset_n` is 1 in every state except MEMRST.
- All outputs are registered.
- `i_go` at cycle t: MEMRST starts at t+1, and `o_start` is high at t+1+MEMRST_CYCLES.
- Capture: `o_capture_count` updates the cycle after `i_valid_result`.
- Read: `o_rd_data` is valid one cycle after `i_rd_addr`, including for an entry written in the same cycle (write-first).
- `o_done` rises one cycle after NEXT or after the timeout cycle.

## Configuration
- `MEST_RUN_CTRL_CHECKSUM_EN`: when defined, adds output `o_checksum` [DATA_WIDTH+1:0].
  - Value is the rotate-left-by-1 XOR of every accepted capture entry.
  - Dropped (overflow) entries are excluded.
  - Cleared on `i_go` and on reset.
- When undefined, the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `mest_run_pkg`: the state enum `run_state_t`, the struct `capture_entry_t` {carry, zero, result}, and a `CAPTURE_W` width function.
- Sub-module `mest_run_capture_ram`: single-write, single-read registered RAM, CAPTURE_DEPTH × (DATA_WIDTH+2), write-first.
- The top level holds the FSM, the counters and the status flags.

## Test plan
- Nominal sequence (NUM_RUNS=2, MEMRST_CYCLES=4):
  - Stimulus: `i_go`; the core model emits 3 results per run (0x11, 0x22, 0x33), then `i_all_done`.
  - Expected: 2 `o_start` pulses, each 4 cycles after its memory reset begins; `o_capture_count`=6; `o_run_count`=2; `o_done`=1; `o_timeout`=0.
- Overflow (CAPTURE_DEPTH=4):
  - Stimulus: 6 results in one run.
  - Expected: count stays at 4, `o_overflow`=1, entries 0..3 read back in order.
- Timeout (TIMEOUT_CYCLES=16):
  - Stimulus: no `i_all_done`.
  - Expected: `o_timeout`=1 and DONE 16 cycles after `o_start`; `o_run_count`=0; no second run.
- Simultaneous valid and all_done:
  - Stimulus: `i_valid_result` and `i_all_done` in the same cycle, with result 0xA5, carry=1, zero=0.
  - Expected: entry read back = 10'b10_1010_0101; run advances.
- Reset during RUN:
  - Stimulus: assert `i_reset` mid-run, then issue `i_go`.
  - Expected: every output returns to its reset value; counts restart from 0.
- Checksum (macro defined):
  - Stimulus: capture entries 0x001 then 0x002.
  - Expected: `o_checksum`=0x000 (rotl(0x001)^0x002).
